// File: rtl/canvas_dump_reader_pkg.sv
// Shared definitions for the paint canvas writer and the canvas dump reader:
// canvas geometry defaults, coordinate width, stream framing constants and
// the dump reader state encoding.
package canvas_dump_reader_pkg;

    localparam int         COORD_W           = 11;
    localparam int         W_RES_DEFAULT     = 640;
    localparam int         H_RES_DEFAULT     = 480;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Header is SYNC, width hi/lo, height hi/lo.
    localparam int         HDR_LEN           = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_LATCH,
        ST_SEND_R,
        ST_SEND_G,
        ST_SEND_B,
        ST_SUM,
        ST_DONE
    } dump_state_t;

    // Header byte for a given index; out-of-range indices return zero.
    function automatic logic [7:0] header_byte(
        input logic [2:0]  idx,
        input logic [7:0]  sync,
        input logic [15:0] width,
        input logic [15:0] height
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = width[15:8];
            3'd2:    b = width[7:0];
            3'd3:    b = height[15:8];
            3'd4:    b = height[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/canvas_dump_reader.sv
// Canvas dump reader: on start, walks the R/G/B frame buffers in raster order
// and emits SYNC, width, height, R/G/B per pixel and an XOR checksum of the
// pixel bytes over a valid/ready byte stream. The buffers answer one cycle
// after the address, so each pixel spends one cycle in FETCH (address
// settling) and one in LATCH (data capture) before its three bytes go out.
module canvas_dump_reader
    import canvas_dump_reader_pkg::*;
#(
    parameter int         W_RES     = W_RES_DEFAULT,
    parameter int         H_RES     = H_RES_DEFAULT,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic [7:0]         rd_r,
    input  logic [7:0]         rd_g,
    input  logic [7:0]         rd_b,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(W_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(H_RES - 1);
    localparam logic [15:0]        WIDTH16  = 16'(W_RES);
    localparam logic [15:0]        HEIGHT16 = 16'(H_RES);
    localparam logic [2:0]         HDR_LAST = 3'(HDR_LEN - 1);

    dump_state_t        state_reg,    state_next;
    logic [2:0]         hdr_idx_reg,  hdr_idx_next;
    logic [COORD_W-1:0] rd_x_reg,     rd_x_next;
    logic [COORD_W-1:0] rd_y_reg,     rd_y_next;
    logic [7:0]         pix_g_reg,    pix_g_next;
    logic [7:0]         pix_b_reg,    pix_b_next;
    logic [7:0]         checksum_reg, checksum_next;
    logic [7:0]         tx_data_reg,  tx_data_next;
    logic               tx_valid_reg, tx_valid_next;

    logic               xfer;
    logic [7:0]         checksum_upd;

    assign xfer         = tx_valid_reg && tx_ready;
    assign checksum_upd = checksum_reg ^ tx_data_reg;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            hdr_idx_reg  <= 3'd0;
            rd_x_reg     <= '0;
            rd_y_reg     <= '0;
            pix_g_reg    <= 8'h00;
            pix_b_reg    <= 8'h00;
            checksum_reg <= 8'h00;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hdr_idx_reg  <= hdr_idx_next;
            rd_x_reg     <= rd_x_next;
            rd_y_reg     <= rd_y_next;
            pix_g_reg    <= pix_g_next;
            pix_b_reg    <= pix_b_next;
            checksum_reg <= checksum_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
        end
    end

    // Next-state and datapath decisions; the next byte is loaded on the
    // transfer edge so back-to-back bytes flow at one per cycle.
    always_comb begin
        state_next    = state_reg;
        hdr_idx_next  = hdr_idx_reg;
        rd_x_next     = rd_x_reg;
        rd_y_next     = rd_y_reg;
        pix_g_next    = pix_g_reg;
        pix_b_next    = pix_b_reg;
        checksum_next = checksum_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;

        case (state_reg)
            ST_IDLE: begin
                tx_valid_next = 1'b0;
                if (start) begin
                    state_next    = ST_HDR;
                    hdr_idx_next  = 3'd0;
                    checksum_next = 8'h00;
                    rd_x_next     = '0;
                    rd_y_next     = '0;
                end
            end

            ST_HDR: begin
                if (!tx_valid_reg) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = header_byte(hdr_idx_reg, SYNC_BYTE, WIDTH16, HEIGHT16);
                end else if (xfer) begin
                    if (hdr_idx_reg == HDR_LAST) begin
                        tx_valid_next = 1'b0;
                        rd_x_next     = '0;
                        rd_y_next     = '0;
                        state_next    = ST_FETCH;
                    end else begin
                        hdr_idx_next  = hdr_idx_reg + 3'd1;
                        tx_data_next  = header_byte(hdr_idx_reg + 3'd1, SYNC_BYTE, WIDTH16, HEIGHT16);
                    end
                end
            end

            ST_FETCH: begin
                state_next = ST_LATCH;
            end

            ST_LATCH: begin
                // Red goes straight to the output register; green and blue
                // are held so later buffer writes cannot reach this pixel.
                tx_data_next  = rd_r;
                pix_g_next    = rd_g;
                pix_b_next    = rd_b;
                tx_valid_next = 1'b1;
                state_next    = ST_SEND_R;
            end

            ST_SEND_R: begin
                if (xfer) begin
                    checksum_next = checksum_upd;
                    tx_data_next  = pix_g_reg;
                    state_next    = ST_SEND_G;
                end
            end

            ST_SEND_G: begin
                if (xfer) begin
                    checksum_next = checksum_upd;
                    tx_data_next  = pix_b_reg;
                    state_next    = ST_SEND_B;
                end
            end

            ST_SEND_B: begin
                if (xfer) begin
                    checksum_next = checksum_upd;
                    if (rd_x_reg < X_LAST) begin
                        rd_x_next     = rd_x_reg + 1'b1;
                        tx_valid_next = 1'b0;
                        state_next    = ST_FETCH;
                    end else if (rd_y_reg < Y_LAST) begin
                        rd_x_next     = '0;
                        rd_y_next     = rd_y_reg + 1'b1;
                        tx_valid_next = 1'b0;
                        state_next    = ST_FETCH;
                    end else begin
                        // Checksum including the final blue byte goes out next.
                        tx_data_next  = checksum_upd;
                        state_next    = ST_SUM;
                    end
                end
            end

            ST_SUM: begin
                if (xfer) begin
                    tx_valid_next = 1'b0;
                    state_next    = ST_DONE;
                end
            end

            ST_DONE: begin
                tx_valid_next = 1'b0;
                state_next    = ST_IDLE;
            end

            default: begin
                tx_valid_next = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done     = (state_reg == ST_DONE);
    assign rd_x     = rd_x_reg;
    assign rd_y     = rd_y_reg;
    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_canvas_dump_reader.sv
// Bench for canvas_dump_reader on a 2x2 canvas with a synthetic frame buffer
// (registered read) and a synthetic byte sink with selectable ready pattern.
module tb_canvas_dump_reader;

    localparam int WR        = 2;
    localparam int HR        = 2;
    localparam int FRAME_LEN = 6 + 3 * WR * HR;
    localparam int BUDGET    = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [10:0] rd_x;
    logic [10:0] rd_y;
    logic [7:0]  rd_r = 8'h00;
    logic [7:0]  rd_g = 8'h00;
    logic [7:0]  rd_b = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    logic [7:0]  salt = 8'h00;
    logic        corrupt = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  rx_bytes[$];

    always #5 clk = ~clk;

    canvas_dump_reader #(
        .W_RES     (WR),
        .H_RES     (HR),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_r     (rd_r),
        .rd_g     (rd_g),
        .rd_b     (rd_b),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    // Frame buffer: R=16y+x (+salt at pixel 0,0), G=0x40+x, B=0x80+y,
    // returned one cycle after the address; pixel (1,0) reads as EE when corrupted.
    always_ff @(posedge clk) begin
        if (corrupt && rd_x == 11'd1 && rd_y == 11'd0) begin
            rd_r <= 8'hEE;
            rd_g <= 8'hEE;
            rd_b <= 8'hEE;
        end else begin
            rd_r <= {rd_y[3:0], rd_x[3:0]} + ((rd_x == 11'd0 && rd_y == 11'd0) ? salt : 8'h00);
            rd_g <= 8'h40 + rd_x[7:0];
            rd_b <= 8'h80 + rd_y[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One run: nfr frames, ready pattern rmode (0 = always, 1 = one cycle in three),
    // optional held start, reset after rst_at transfers, buffer corruption after
    // LATCH of pixel (1,0), and a stray start pulse after mid_at transfers.
    task automatic run(input string name, input int nfr, input int rmode,
                       input logic [7:0] salt_in, input logic [7:0] exp_cs,
                       input bit hold, input int rst_at, input bit corr, input int mid_at);
        int         cyc = 0;
        int         dones = 0;
        int         first_valid = -1;
        int         lowrun = -1;
        int         c_lat = -1;
        int         n_cmp;
        bit         pend = 1'b0;
        bit         mid_done = 1'b0;
        bit         aborted = 1'b0;
        logic [7:0] pend_data = 8'h00;
        logic [7:0] exp_f[FRAME_LEN];

        exp_f = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02,
                  salt_in, 8'h40, 8'h80,
                  8'h01,   8'h41, 8'h80,
                  8'h10,   8'h40, 8'h81,
                  8'h11,   8'h41, 8'h81,
                  exp_cs};
        salt = salt_in;
        rx_bytes.delete();

        @(negedge clk);
        start    = 1'b1;
        tx_ready = (rmode == 0);

        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;

            if (rst_at >= 0 && rx_bytes.size() == rst_at) begin
                int stray_done = 0;
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check($sformatf("%s tx_valid after reset", name), tx_valid, 1'b0);
                check($sformatf("%s busy after reset", name), busy, 1'b0);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (done) stray_done++;
                end
                check($sformatf("%s done after reset", name), stray_done, 0);
                aborted = 1'b1;
                break;
            end

            if (!hold) start = 1'b0;
            if (mid_at >= 0 && !mid_done && rx_bytes.size() == mid_at) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            tx_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);

            if (pend) begin
                check($sformatf("%s held valid", name), tx_valid, 1'b1);
                check($sformatf("%s held data", name), tx_data, pend_data);
            end
            if (first_valid < 0 && tx_valid) begin
                first_valid = cyc;
                check($sformatf("%s start latency", name), first_valid, 2);
            end
            if (corr && c_lat < 0 && tx_valid && rx_bytes.size() == 8) c_lat = cyc;
            if (corr && c_lat >= 0 && cyc == c_lat + 1) corrupt = 1'b1;

            if (done) begin
                dones++;
                check($sformatf("%s busy with done", name), busy, 1'b0);
                lowrun = 0;
            end else if (lowrun >= 0) begin
                if (busy) begin
                    if (hold) check($sformatf("%s idle gap", name), lowrun, 1);
                    lowrun = -1;
                end else begin
                    lowrun++;
                end
            end

            pend      = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (tx_valid && tx_ready) rx_bytes.push_back(tx_data);
            if (dones == nfr) break;
        end
        start   = 1'b0;
        corrupt = 1'b0;

        if (cyc >= BUDGET) check($sformatf("%s timeout", name), 0, 1);
        if (!aborted) begin
            check($sformatf("%s byte count", name), rx_bytes.size(), nfr * FRAME_LEN);
            check($sformatf("%s done count", name), dones, nfr);
            n_cmp = (rx_bytes.size() < nfr * FRAME_LEN) ? rx_bytes.size() : nfr * FRAME_LEN;
            for (int i = 0; i < n_cmp; i++) begin
                check($sformatf("%s byte %0d", name, i), rx_bytes[i], exp_f[i % FRAME_LEN]);
            end
        end
        $display("run %s: %0d bytes, %0d done pulses, %0d cycles", name, rx_bytes.size(), dones, cyc);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy",     busy,     1'b0);
        check("reset done",     done,     1'b0);
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_data",  tx_data,  8'h00);
        check("reset rd_x",     rd_x,     11'd0);
        check("reset rd_y",     rd_y,     11'd0);
        rst = 1'b0;
        @(negedge clk);

        //  name         nfr rmode salt   cs     hold rst_at corr mid_at
        run("basic",      1,  0,   8'h00, 8'h00, 0,   -1,    0,   -1);
        run("throttled",  1,  1,   8'h3C, 8'h3C, 0,   -1,    0,   -1);
        run("held_pixel", 1,  1,   8'h00, 8'h00, 0,   -1,    1,   -1);
        run("reset_mid",  1,  0,   8'h00, 8'h00, 0,    8,    0,   -1);
        run("after_rst",  1,  0,   8'h5A, 8'h5A, 0,   -1,    0,   -1);
        run("stray_start",1,  0,   8'h00, 8'h00, 0,   -1,    0,    6);
        run("back2back",  3,  0,   8'h00, 8'h00, 1,   -1,    0,   -1);

        check("final idle busy", busy, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/canvas_dump_reader.md
Name: canvas_dump_reader

Overview:
Read-side counterpart of the paint canvas writer. On request, it scans the R/G/B frame buffers in raster order and serialises the canvas into a framed byte stream for a downstream byte transmitter (UART TX). It owns the buffer read-address port, so the host mux routes rd_x/rd_y to the buffers while busy is high. It shares the pixel-buffer read timing: data returns one cycle after the address.

Parameters:
W_RES, 640, canvas width in pixels (11-bit coordinate space)
H_RES, 480, canvas height in pixels
SYNC_BYTE, 8'hA5, frame start marker

Ports:
CLOCK_50  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  level; sampled in IDLE, begins one dump
busy  output  1  high from the cycle after start is accepted until the trailer byte is accepted
done  output  1  one-cycle pulse after the trailer byte transfers
rd_x  output  11  buffer read column
rd_y  output  11  buffer read row
rd_r  input  8  red buffer data, valid 1 cycle after rd_x/rd_y
rd_g  input  8  green buffer data, same timing as rd_r
rd_b  input  8  blue buffer data, same timing as rd_r
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  transmitter accepts the byte this cycle

Behaviour:
- Reset state: IDLE.
  - Outputs under reset: busy=0, done=0, rd_x=0, rd_y=0, tx_valid=0, tx_data=0.
  - Pixel counters and checksum are cleared.
- Handshake:
  - A byte transfers on the clock edge where tx_valid && tx_ready.
  - tx_valid, once raised, stays high and tx_data stays stable until that transfer.
  - The next byte may be presented on the cycle after the transfer, giving a max throughput of 1 byte/cycle.
- Frame format, bytes in order:
  - SYNC_BYTE
  - W_RES[15:8], W_RES[7:0]
  - H_RES[15:8], H_RES[7:0]
  - For each pixel, row 0 first and x ascending within each row: R, G, B
  - Checksum: XOR of all pixel bytes only, excluding the header
- States:
  - IDLE: start=1 -> HDR, byte index 0.
  - HDR: present the 5 header bytes in order. After the 5th transfer, set rd_x=0, rd_y=0 and go to FETCH.
  - FETCH: rd_x/rd_y are held stable for one cycle -> LATCH.
  - LATCH: capture rd_r/g/b into holding registers -> SEND_R.
  - SEND_R / SEND_G / SEND_B: present the held byte. On transfer, XOR it into the checksum and advance.
  - After SEND_B transfers:
    - If rd_x < W_RES-1: rd_x+1 -> FETCH.
    - Else if rd_y < H_RES-1: rd_x=0, rd_y+1 -> FETCH.
    - Else -> SUM.
  - SUM: present the checksum. On transfer -> DONE_ST.
  - DONE_ST: done=1 and busy=0 for this one cycle -> IDLE.
- rd_x/rd_y must not change between FETCH and LATCH. Held bytes are immune to buffer changes after LATCH.
- start while busy is ignored. start held high re-triggers only after passing through IDLE, so the minimum gap between frames is 1 IDLE cycle.
- tx_ready high while tx_valid is low has no effect.
- Reset asserted mid-frame:
  - Returns to IDLE next edge and drops tx_valid.
  - The partial frame is abandoned: no checksum and no done.
- Counter widths: rd_x/rd_y are 11 bits. The last pixel index (W_RES-1, H_RES-1) never wraps.
- Total transfers per frame: 6 + 3·W_RES·H_RES.
- Latency: start to first tx_valid is 2 cycles. IDLE -> HDR is registered, and tx_valid is registered in HDR.

Decomposition:
- Shared package, used by both the writer and this block:
  - W_RES/H_RES defaults
  - SYNC_BYTE
  - Coordinate width constant (11)
  - State encoding constants
- Natural sub-module: uart_tx_byte. It takes tx_data/tx_valid/tx_ready in and drives a serial line at a divisor parameter. It is instantiated beside this block at top level, not inside it, so the stream is testable with a synthetic sink.

Test Plan:
- W_RES=2, H_RES=2; buffer pixel (x,y) = R=16y+x, G=0x40+x, B=0x80+y; tx_ready tied 1; start pulse -> exactly 18 bytes:
  - A5 00 02 00 02
  - 00 40 80, 01 41 80, 10 40 81, 11 41 81
  - checksum = XOR of those 12 bytes
  - Then done pulses once and busy falls with done.
- Same stimulus, tx_ready toggling 1-of-3 cycles -> identical byte sequence; tx_data stable whenever tx_valid && !tx_ready.
- Pixel data changed 2 cycles after LATCH of pixel (1,0) -> old values 01 41 80 transmitted.
- Reset pulsed after the 8th transfer -> tx_valid=0 next cycle, busy=0, no done; new start produces a full, correct frame.
- start held high for 3 frames -> three back-to-back frames separated by exactly 1 IDLE cycle; start pulse during SEND_G ignored.
- Default 640x480 with ready=1 -> 921606 transfers; last pixel read at rd_x=639, rd_y=479; no coordinate wrap.
